// File: rtl/jtag_pkg.sv
// Shared TAP types: state encoding, opcode constants and the
// instruction-to-data-register decode used by the controller.
package jtag_pkg;

  // Standard 1149.1 state encoding (matches the usual debugger view)
  typedef enum logic [3:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PA_DR  = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PA_IR  = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_e;

  localparam int OP_IDCODE    = 1;
  localparam int OP_USER_BASE = 2;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_kind_e;

  typedef struct packed {
    dr_kind_e   kind;
    logic [7:0] idx;
  } dr_sel_t;

  // Decode an instruction into the data register it routes to.
  // All-ones and every unassigned opcode fall back to BYPASS.
  function automatic dr_sel_t opcode_to_sel(input logic [31:0] op,
                                            input int ir_width,
                                            input int num_dr);
    dr_sel_t     sel;
    logic [31:0] all_ones;
    all_ones = (32'd1 << ir_width) - 32'd1;
    sel.kind = DR_BYPASS;
    sel.idx  = 8'd0;
    if (op == all_ones) begin
      sel.kind = DR_BYPASS;
    end else if (op == 32'(OP_IDCODE)) begin
      sel.kind = DR_IDCODE;
    end else if ((op >= 32'(OP_USER_BASE)) && (op < 32'(OP_USER_BASE + num_dr))) begin
      sel.kind = DR_USER;
      sel.idx  = 8'(op - 32'(OP_USER_BASE));
    end else begin
      sel.kind = DR_BYPASS;
    end
    return sel;
  endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// Serial JTAG pins between a bus master (debugger) and the TAP slave.
interface jtag_tap_ctrl_if;
  logic tdi;
  logic tms;
  logic tdo;
  logic tdo_en;

  modport master_mp (output tdi, output tms, input tdo, input tdo_en);
  modport slave_mp  (input tdi, input tms, output tdo, output tdo_en);
endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP state machine; state register is the output.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e tap_state
);

  // Advance the TAP graph on every rising tck according to tms
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      tap_state <= TLR;
    end else begin
      case (tap_state)
        TLR:     tap_state <= tms ? TLR    : RTI;
        RTI:     tap_state <= tms ? SEL_DR : RTI;
        SEL_DR:  tap_state <= tms ? SEL_IR : CAP_DR;
        CAP_DR:  tap_state <= tms ? EX1_DR : SH_DR;
        SH_DR:   tap_state <= tms ? EX1_DR : SH_DR;
        EX1_DR:  tap_state <= tms ? UPD_DR : PA_DR;
        PA_DR:   tap_state <= tms ? EX2_DR : PA_DR;
        EX2_DR:  tap_state <= tms ? UPD_DR : SH_DR;
        UPD_DR:  tap_state <= tms ? SEL_DR : RTI;
        SEL_IR:  tap_state <= tms ? TLR    : CAP_IR;
        CAP_IR:  tap_state <= tms ? EX1_IR : SH_IR;
        SH_IR:   tap_state <= tms ? EX1_IR : SH_IR;
        EX1_IR:  tap_state <= tms ? UPD_IR : PA_IR;
        PA_IR:   tap_state <= tms ? EX2_IR : PA_IR;
        EX2_IR:  tap_state <= tms ? UPD_IR : SH_IR;
        UPD_IR:  tap_state <= tms ? SEL_DR : RTI;
        default: tap_state <= TLR;
      endcase
    end
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: IR, BYPASS, IDCODE and NUM_DR user data registers
// with parallel capture/update ports for on-chip test logic.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter int          DR_WIDTH   = 16,
  parameter int          NUM_DR     = 2,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                       tck,
  input  logic                       trst,
  jtag_tap_ctrl_if.slave_mp          jtag,
  output tap_state_e                 tap_state,
  output logic [IR_WIDTH-1:0]        ir_q,
  input  logic [NUM_DR*DR_WIDTH-1:0] dr_capture,
  output logic [NUM_DR*DR_WIDTH-1:0] dr_update,
  output logic [NUM_DR-1:0]          dr_update_stb
);

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  dr_sel_t             sel_s;
  logic [DR_WIDTH-1:0] cap_slice_s;
  logic                dr_lsb_s;
  logic                upd_entry_s;
  logic                tlr_entry_s;

  logic [IR_WIDTH-1:0] ir_shift_r;
  logic                bypass_r;
  logic [31:0]         idcode_r;
  logic [DR_WIDTH-1:0] user_r;
  logic                tdo_r;
  logic                tdo_en_r;

  jtag_tap_fsm u_fsm (
    .tck       (tck),
    .trst      (trst),
    .tms       (jtag.tms),
    .tap_state (tap_state)
  );

  assign sel_s = opcode_to_sel(32'(ir_q), IR_WIDTH, NUM_DR);

  // Update commits on the edge that enters UPD_DR so the strobe spans that state
  assign upd_entry_s = ((tap_state == EX1_DR) || (tap_state == EX2_DR)) && jtag.tms;
  // Entering TLR from SEL_IR: IDCODE is visible as soon as TLR is
  assign tlr_entry_s = (tap_state == SEL_IR) && jtag.tms;

  // Pick the dr_capture slice belonging to the selected user register
  always_comb begin
    cap_slice_s = '0;
    for (int i = 0; i < NUM_DR; i++) begin
      if (sel_s.idx == 8'(i)) begin
        cap_slice_s = dr_capture[i*DR_WIDTH +: DR_WIDTH];
      end else begin
        cap_slice_s = cap_slice_s;
      end
    end
  end

  // Serial output bit of the currently selected data register
  always_comb begin
    case (sel_s.kind)
      DR_BYPASS: dr_lsb_s = bypass_r;
      DR_IDCODE: dr_lsb_s = idcode_r[0];
      DR_USER:   dr_lsb_s = user_r[0];
      default:   dr_lsb_s = bypass_r;
    endcase
  end

  // Instruction shift register and active instruction
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_shift_r <= '0;
      ir_q       <= IR_IDCODE;
    end else begin
      case (tap_state)
        CAP_IR:  ir_shift_r <= IR_CAPTURE;
        SH_IR:   ir_shift_r <= {jtag.tdi, ir_shift_r[IR_WIDTH-1:1]};
        default: ir_shift_r <= ir_shift_r;
      endcase
      if (tap_state == UPD_IR) begin
        ir_q <= ir_shift_r;
      end else if ((tap_state == TLR) || tlr_entry_s) begin
        ir_q <= IR_IDCODE;
      end else begin
        ir_q <= ir_q;
      end
    end
  end

  // Data shift registers: capture into and shift only the selected one
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      bypass_r <= 1'b0;
      idcode_r <= 32'h0;
      user_r   <= '0;
    end else begin
      case (tap_state)
        CAP_DR: begin
          case (sel_s.kind)
            DR_IDCODE: idcode_r <= IDCODE_VAL;
            DR_USER:   user_r   <= cap_slice_s;
            default:   bypass_r <= 1'b0;
          endcase
        end
        SH_DR: begin
          case (sel_s.kind)
            DR_IDCODE: idcode_r <= {jtag.tdi, idcode_r[31:1]};
            DR_USER:   user_r   <= (user_r >> 1) | (DR_WIDTH'(jtag.tdi) << (DR_WIDTH - 1));
            default:   bypass_r <= jtag.tdi;
          endcase
        end
        default: begin
          bypass_r <= bypass_r;
          idcode_r <= idcode_r;
          user_r   <= user_r;
        end
      endcase
    end
  end

  // Parallel update of the selected user slice plus its one-cycle strobe
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      dr_update     <= '0;
      dr_update_stb <= '0;
    end else begin
      dr_update_stb <= '0;
      if (upd_entry_s && (sel_s.kind == DR_USER)) begin
        for (int i = 0; i < NUM_DR; i++) begin
          if (sel_s.idx == 8'(i)) begin
            dr_update[i*DR_WIDTH +: DR_WIDTH] <= user_r;
            dr_update_stb[i]                  <= 1'b1;
          end
        end
      end
    end
  end

  // tdo/tdo_en launch on the falling edge so the debugger samples mid-bit
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo_r    <= 1'b0;
      tdo_en_r <= 1'b0;
    end else begin
      case (tap_state)
        SH_DR: begin
          tdo_r    <= dr_lsb_s;
          tdo_en_r <= 1'b1;
        end
        SH_IR: begin
          tdo_r    <= ir_shift_r[0];
          tdo_en_r <= 1'b1;
        end
        default: begin
          tdo_r    <= 1'b0;
          tdo_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign jtag.tdo    = tdo_r;
  assign jtag.tdo_en = tdo_en_r;

endmodule
